// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory-stage load/store unit. Runs a req/gnt/rvalid
//            handshake with data memory, generates byte enables and
//            lane-replicated store data, extends load data, and stalls
//            the pipeline while an access is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_o,
  output logic [31:0] misalign_addr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        legal;
  logic        misaligned;
  logic        go;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext_data;

  // Decode legality and alignment of the instruction in the EX/MEM slot
  always_comb begin
    logic f3_ok;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ex_load;   // unsigned widths exist only for loads
      default:                f3_ok = 1'b0;
    endcase
    legal      = ex_valid && (ex_load != ex_store) && f3_ok;
    misaligned = legal && (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                           ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
    go         = legal && !misaligned;
  end

  // Byte enables and lane-replicated store data for the incoming access
  always_comb begin
    case (ex_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << ex_addr[1:0];
        wdata_n = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = ex_wdata;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    case (off_q)
      2'd0:    rbyte = dmem_rdata[7:0];
      2'd1:    rbyte = dmem_rdata[15:8];
      2'd2:    rbyte = dmem_rdata[23:16];
      default: rbyte = dmem_rdata[31:24];
    endcase
    rhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  ext_data = {24'd0, rbyte};
      3'b001:  ext_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  ext_data = {16'd0, rhalf};
      default: ext_data = dmem_rdata;
    endcase
  end

  // Stall while an access is pending, released in its completion cycle
  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  stall_o = go;
        S_REQ:   stall_o = !(dmem_gnt && dmem_we);
        S_WAIT:  stall_o = !dmem_rvalid;
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign dmem_req = (state == S_REQ);

  // Handshake FSM with registered memory request and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_be       <= 4'd0;
      dmem_wdata    <= 32'd0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      rd_q          <= 5'd0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      misalign_o    <= 1'b0;
      misalign_addr <= 32'd0;
    end else begin
      wb_valid   <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (misaligned) begin
            misalign_o    <= 1'b1;
            misalign_addr <= ex_addr;
          end else if (go) begin
            dmem_we    <= ex_store;
            dmem_addr  <= {ex_addr[31:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            funct3_q   <= ex_funct3;
            off_q      <= ex_addr[1:0];
            rd_q       <= ex_rd;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem_gnt) state <= dmem_we ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            wb_valid <= 1'b1;
            wb_data  <= ext_data;
            wb_rd    <= rd_q;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_o;
  logic [31:0] misalign_addr;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_o(misalign_o), .misalign_addr(misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic clear_ex;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
  endtask

  // Store with grant on the first REQ cycle
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
    issue(1'b0, 1'b1, f3, a, wd, 5'd0);
    #1 chk({tag, ".idle_stall"}, {31'd0, stall_o}, 32'd1);
    chk({tag, ".idle_req"}, {31'd0, dmem_req}, 32'd0);
    tick;
    dmem_gnt = 1'b1;
    #1 chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, ".we"}, {31'd0, dmem_we}, 32'd1);
    chk({tag, ".addr"}, dmem_addr, e_addr);
    chk({tag, ".be"}, {28'd0, dmem_be}, {28'd0, e_be});
    chk({tag, ".wdata"}, dmem_wdata, e_wd);
    chk({tag, ".done_stall"}, {31'd0, stall_o}, 32'd0);
    tick;
    dmem_gnt = 1'b0;
    clear_ex;
    #1 chk({tag, ".after_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, ".no_wb"}, {31'd0, wb_valid}, 32'd0);
  endtask

  // Load with immediate grant and read data one cycle later
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] e_addr, input logic [31:0] e_data);
    issue(1'b1, 1'b0, f3, a, 32'd0, rd);
    #1 chk({tag, ".idle_stall"}, {31'd0, stall_o}, 32'd1);
    tick;
    dmem_gnt = 1'b1;
    #1 chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, ".we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, ".addr"}, dmem_addr, e_addr);
    chk({tag, ".req_stall"}, {31'd0, stall_o}, 32'd1);
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1 chk({tag, ".wait_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, ".wait_req"}, {31'd0, dmem_req}, 32'd0);
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    clear_ex;
    #1 chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, ".wb_data"}, wb_data, e_data);
    chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    tick;
    #1 chk({tag, ".wb_pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    int sc;
    int wbc;
    // Reset with a legal op presented: stall must be held low
    rst = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
    tick;
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    chk("rst.req", {31'd0, dmem_req}, 32'd0);
    chk("rst.we", {31'd0, dmem_we}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.be", {28'd0, dmem_be}, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.misalign", {31'd0, misalign_o}, 32'd0);
    rst = 1'b0;
    clear_ex;
    tick;

    // Stores
    do_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
    do_store("sb", 3'b000, 32'h105, 32'h000000AB, 32'h104, 4'b0010, 32'hABABABAB);
    do_store("sh", 3'b001, 32'h106, 32'h00001234, 32'h104, 4'b1100, 32'h12341234);

    // Loads with sign/zero extension
    do_load("lb",  3'b000, 32'h203, 32'h80000000, 5'd7,  32'h200, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80000000, 5'd8,  32'h200, 32'h00000080);
    do_load("lh",  3'b001, 32'h202, 32'h80011234, 5'd10, 32'h200, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h202, 32'h80011234, 5'd11, 32'h200, 32'h00008001);
    do_load("lb1", 3'b000, 32'h211, 32'h00007F00, 5'd12, 32'h210, 32'h0000007F);

    // Misaligned word load
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 5'd5);
    #1 chk("mis.stall", {31'd0, stall_o}, 32'd0);
    tick;
    clear_ex;
    #1 chk("mis.req", {31'd0, dmem_req}, 32'd0);
    chk("mis.strobe", {31'd0, misalign_o}, 32'd1);
    chk("mis.addr", misalign_addr, 32'h102);
    tick;
    #1 chk("mis.pulse", {31'd0, misalign_o}, 32'd0);

    // Illegal encodings: both load and store, and unsigned-width store
    issue(1'b1, 1'b1, 3'b010, 32'h300, 32'd0, 5'd1);
    #1 chk("ill.both_stall", {31'd0, stall_o}, 32'd0);
    tick;
    issue(1'b0, 1'b1, 3'b100, 32'h300, 32'd0, 5'd1);
    #1 chk("ill.both_req", {31'd0, dmem_req}, 32'd0);
    chk("ill.st_stall", {31'd0, stall_o}, 32'd0);
    tick;
    clear_ex;
    #1 chk("ill.st_req", {31'd0, dmem_req}, 32'd0);
    chk("ill.misalign", {31'd0, misalign_o}, 32'd0);

    // Grant backpressure: three cycles without gnt, rvalid two cycles after gnt
    tick;
    sc = 0; wbc = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd9);
    #1 sc += int'(stall_o);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1 sc += int'(stall_o);
      chk("bp.req", {31'd0, dmem_req}, 32'd1);
      chk("bp.addr", dmem_addr, 32'h400);
    end
    tick;
    dmem_gnt = 1'b1;
    #1 sc += int'(stall_o);
    chk("bp.req_gnt", {31'd0, dmem_req}, 32'd1);
    chk("bp.addr_gnt", dmem_addr, 32'h400);
    tick;
    dmem_gnt = 1'b0;
    #1 sc += int'(stall_o);
    wbc += int'(wb_valid);
    chk("bp.wait_req", {31'd0, dmem_req}, 32'd0);
    tick;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #1 sc += int'(stall_o);
    wbc += int'(wb_valid);
    tick;
    dmem_rvalid = 1'b0;
    clear_ex;
    #1 sc += int'(stall_o);
    wbc += int'(wb_valid);
    chk("bp.wb_data", wb_data, 32'hCAFEF00D);
    chk("bp.wb_rd", {27'd0, wb_rd}, 32'd9);
    tick;
    #1 sc += int'(stall_o);
    wbc += int'(wb_valid);
    chk("bp.stall_cycles", sc, 32'd6);
    chk("bp.wb_pulses", wbc, 32'd1);

    // Back-to-back loads: second accepted in the first's wb_valid cycle
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd3);
    tick;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    tick;
    dmem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b101, 32'h302, 32'd0, 5'd4);
    #1 chk("b2b.wb1_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b.wb1_data", wb_data, 32'h11223344);
    chk("b2b.stall2", {31'd0, stall_o}, 32'd1);
    tick;
    dmem_gnt = 1'b1;
    #1 chk("b2b.req2", {31'd0, dmem_req}, 32'd1);
    chk("b2b.addr2", dmem_addr, 32'h300);
    chk("b2b.be2", {28'd0, dmem_be}, 32'hC);
    tick;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF0000;
    tick;
    dmem_rvalid = 1'b0;
    clear_ex;
    #1 chk("b2b.wb2_data", wb_data, 32'h0000BEEF);
    chk("b2b.wb2_rd", {27'd0, wb_rd}, 32'd4);
    tick;

    // Reset while waiting for read data; late rvalid is discarded
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 5'd6);
    tick;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_ex;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h00000055;
    #1 chk("rstw.req", {31'd0, dmem_req}, 32'd0);
    chk("rstw.stall", {31'd0, stall_o}, 32'd0);
    chk("rstw.addr", dmem_addr, 32'd0);
    chk("rstw.be", {28'd0, dmem_be}, 32'd0);
    chk("rstw.wb_data", wb_data, 32'd0);
    tick;
    dmem_rvalid = 1'b0;
    #1 chk("rstw.no_wb", {31'd0, wb_valid}, 32'd0);
    chk("rstw.wb_data2", wb_data, 32'd0);
    tick;
    do_store("post_rst_sb", 3'b000, 32'h602, 32'h0000005A, 32'h600, 4'b0100, 32'h5A5A5A5A);

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
